// File: rtl/victim_write_buffer.sv
// victim_write_buffer: line-granularity write buffer between the cache memory
// port and main memory. Evictions are queued in a circular FIFO and drained
// in the background; reads hitting a buffered line are forwarded locally.
// Optional feature macro: WBUF_COALESCE_EN (merge writes into a waiting entry).
module victim_write_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 8,
    parameter int DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_LEN-1:0]             up_addr,
    input  logic                            up_rd_req,
    input  logic                            up_wr_req,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  up_wr_line,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  up_rd_line,
    output logic                            up_gnt,
    output logic [ADDR_LEN-1:0]             dn_addr,
    output logic                            dn_rd_req,
    output logic                            dn_wr_req,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  dn_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  dn_rd_line,
    input  logic                            dn_gnt,
    output logic                            full,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int LINE_W = 32 << LINE_ADDR_LEN;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_MEM, RD_DONE} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       head, tail;
    logic [DEPTH-1:0]    valid;
    logic [ADDR_LEN-1:0] entry_addr [DEPTH];
    logic [LINE_W-1:0]   entry_line [DEPTH];
    logic [ADDR_LEN-1:0] rd_addr;

    logic                hit;
    logic [PW-1:0]       hit_idx;
    logic [PW-1:0]       scan_idx;
`ifdef WBUF_COALESCE_EN
    logic                co_hit;
    logic [PW-1:0]       co_idx;
`endif

    logic up_idle, rd_fwd, rd_miss, wr_alloc, wr_merge, pop, rd_fill;

    assign full = (count == CW'(DEPTH));

    // Address match scan, oldest to youngest so the youngest match wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
`ifdef WBUF_COALESCE_EN
        co_hit   = 1'b0;
        co_idx   = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (valid[scan_idx] && entry_addr[scan_idx] == up_addr) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
`ifdef WBUF_COALESCE_EN
                if (!(state == DRAIN && scan_idx == head)) begin
                    co_hit = 1'b1;
                    co_idx = scan_idx;
                end
`endif
            end
        end
    end

    // A request is only sampled outside its own grant cycle and outside a miss.
    assign up_idle  = !up_gnt && state != RD_MEM && state != RD_DONE;
    assign rd_fwd   = up_idle && up_rd_req && hit;
    assign rd_miss  = up_idle && up_rd_req && !hit;
    assign pop      = (state == DRAIN) && dn_gnt;
    assign rd_fill  = (state == RD_MEM) && dn_gnt;
`ifdef WBUF_COALESCE_EN
    assign wr_merge = up_idle && up_wr_req && co_hit;
    assign wr_alloc = up_idle && up_wr_req && !co_hit && !full;
`else
    assign wr_merge = 1'b0;
    assign wr_alloc = up_idle && up_wr_req && !full;
`endif

    // Drain/read FSM next state and memory-side outputs.
    always_comb begin
        state_nx   = state;
        dn_rd_req  = 1'b0;
        dn_wr_req  = 1'b0;
        dn_addr    = '0;
        dn_wr_line = '0;
        case (state)
            IDLE: begin
                if (rd_miss)
                    state_nx = RD_MEM;
                else if (count != '0)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                dn_wr_req  = 1'b1;
                dn_addr    = entry_addr[head];
                dn_wr_line = entry_line[head];
                if (dn_gnt)
                    state_nx = IDLE;
            end
            RD_MEM: begin
                dn_rd_req = 1'b1;
                dn_addr   = rd_addr;
                if (dn_gnt)
                    state_nx = RD_DONE;
            end
            RD_DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control state: FSM, pointers, occupancy, upstream grant and read data.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid      <= '0;
            up_gnt     <= 1'b0;
            up_rd_line <= '0;
            rd_addr    <= '0;
        end else begin
            state  <= state_nx;
            up_gnt <= rd_fwd || wr_alloc || wr_merge || rd_fill;
            if (rd_fwd)
                up_rd_line <= entry_line[hit_idx];
            else if (rd_fill)
                up_rd_line <= dn_rd_line;
            if (state == IDLE && rd_miss)
                rd_addr <= up_addr;
            if (wr_alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            case ({wr_alloc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: address and line payload.
    // NOTE: the payload array is not reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            entry_addr[tail] <= up_addr;
            entry_line[tail] <= up_wr_line;
        end
`ifdef WBUF_COALESCE_EN
        else if (wr_merge) begin
            entry_line[co_idx] <= up_wr_line;
        end
`endif
    end

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed self-checking bench for victim_write_buffer (default parameters).
module tb_victim_write_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   up_addr;
    logic         up_rd_req, up_wr_req;
    logic [255:0] up_wr_line, up_rd_line;
    logic         up_gnt;
    logic [7:0]   dn_addr;
    logic         dn_rd_req, dn_wr_req;
    logic [255:0] dn_wr_line, dn_rd_line;
    logic         dn_gnt;
    logic         full;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;

    victim_write_buffer dut (
        .clk(clk), .rst(rst),
        .up_addr(up_addr), .up_rd_req(up_rd_req), .up_wr_req(up_wr_req),
        .up_wr_line(up_wr_line), .up_rd_line(up_rd_line), .up_gnt(up_gnt),
        .dn_addr(dn_addr), .dn_rd_req(dn_rd_req), .dn_wr_req(dn_wr_req),
        .dn_wr_line(dn_wr_line), .dn_rd_line(dn_rd_line), .dn_gnt(dn_gnt),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] s);
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = s * 32'h0101_0101 + 32'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a write until granted (bounded), check grant latency, release.
    task automatic write_line(input logic [7:0] a, input logic [255:0] d, input int exp_wait);
        int n = 0;
        up_addr = a; up_wr_line = d; up_wr_req = 1'b1;
        do begin
            step();
            n++;
        end while (!up_gnt && n < 16);
        check("wr_gnt_wait", 32'(n), 32'(exp_wait));
        up_wr_req = 1'b0;
        step();
    endtask

    // Check the drain currently presented, then grant it.
    task automatic drain_one(input logic [7:0] a, input logic [255:0] d);
        check("drain_req", 32'(dn_wr_req), 1);
        check("drain_addr", 32'(dn_addr), 32'(a));
        check_line("drain_line", dn_wr_line, d);
        dn_gnt = 1'b1; step();
        dn_gnt = 1'b0; step();
    endtask

    // Forward-hit read: granted one cycle later with no memory access.
    task automatic read_hit(input logic [7:0] a, input logic [255:0] d);
        up_addr = a; up_rd_req = 1'b1;
        step();
        check("fwd_gnt", 32'(up_gnt), 1);
        check_line("fwd_line", up_rd_line, d);
        check("fwd_no_mem", 32'(dn_rd_req), 0);
        up_rd_req = 1'b0;
        step();
        check("fwd_no_mem_after", 32'(dn_rd_req), 0);
    endtask

    initial begin
        rst = 1'b1; up_addr = '0; up_rd_req = 1'b0; up_wr_req = 1'b0;
        up_wr_line = '0; dn_rd_line = '0; dn_gnt = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset values
        check("rst_gnt", 32'(up_gnt), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_dn_wr", 32'(dn_wr_req), 0);
        check("rst_dn_rd", 32'(dn_rd_req), 0);
        check("rst_dn_addr", 32'(dn_addr), 0);
        check_line("rst_dn_line", dn_wr_line, '0);
        check_line("rst_rd_line", up_rd_line, '0);

        // Single write 0x12, drain starts the cycle after the grant
        up_addr = 8'h12; up_wr_line = mk_line(32'h12); up_wr_req = 1'b1;
        step();
        check("w1_gnt", 32'(up_gnt), 1);
        check("w1_count", 32'(count), 1);
        check("w1_no_drain_yet", 32'(dn_wr_req), 0);
        up_wr_req = 1'b0;
        step();
        check("w1_gnt_pulse", 32'(up_gnt), 0);
        drain_one(8'h12, mk_line(32'h12));
        check("w1_count_after", 32'(count), 0);

        // Fill to full with memory stalled
        write_line(8'h01, mk_line(32'h01), 1);
        write_line(8'h02, mk_line(32'h02), 1);
        write_line(8'h03, mk_line(32'h03), 1);
        write_line(8'h04, mk_line(32'h04), 1);
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        check("fill_head_addr", 32'(dn_addr), 32'h01);

        // Fifth write waits for a pop, grant one cycle after it
        up_addr = 8'h05; up_wr_line = mk_line(32'h05); up_wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_no_gnt", 32'(up_gnt), 0);
        end
        dn_gnt = 1'b1; step(); dn_gnt = 1'b0;
        check("pop_cycle_no_gnt", 32'(up_gnt), 0);
        check("pop_cycle_count", 32'(count), 3);
        step();
        check("late_gnt", 32'(up_gnt), 1);
        check("late_count", 32'(count), 4);
        check("late_full", 32'(full), 1);
        up_wr_req = 1'b0;
        step();
        drain_one(8'h02, mk_line(32'h02));
        drain_one(8'h03, mk_line(32'h03));
        drain_one(8'h04, mk_line(32'h04));
        drain_one(8'h05, mk_line(32'h05));
        check("drained_count", 32'(count), 0);

        // Forward hit on the in-flight entry 0x21
        write_line(8'h21, mk_line(32'h21), 1);
        check("hit_inflight", 32'(dn_wr_req), 1);
        read_hit(8'h21, mk_line(32'h21));
        drain_one(8'h21, mk_line(32'h21));

        // Read miss waits for the drain of 0x01, then reads memory
        write_line(8'h01, mk_line(32'h0A), 1);
        up_addr = 8'h30; up_rd_req = 1'b1;
        step(); step();
        check("miss_wait_rd", 32'(dn_rd_req), 0);
        check("miss_wait_wr", 32'(dn_wr_req), 1);
        check("miss_wait_gnt", 32'(up_gnt), 0);
        dn_gnt = 1'b1; step(); dn_gnt = 1'b0;
        check("miss_gap_wr", 32'(dn_wr_req), 0);
        check("miss_gap_rd", 32'(dn_rd_req), 0);
        step();
        check("miss_rd_req", 32'(dn_rd_req), 1);
        check("miss_rd_addr", 32'(dn_addr), 32'h30);
        check("miss_no_wr", 32'(dn_wr_req), 0);
        step();
        check("miss_rd_hold", 32'(dn_rd_req), 1);
        dn_rd_line = mk_line(32'hC3); dn_gnt = 1'b1;
        step();
        dn_gnt = 1'b0; dn_rd_line = '0;
        check("miss_gnt", 32'(up_gnt), 1);
        check_line("miss_line", up_rd_line, mk_line(32'hC3));
        check("miss_rd_drop", 32'(dn_rd_req), 0);
        up_rd_req = 1'b0;
        step();
        check("miss_gnt_pulse", 32'(up_gnt), 0);
        check_line("miss_line_hold", up_rd_line, mk_line(32'hC3));

        // Duplicate address behind an in-flight head
        write_line(8'h50, mk_line(32'h50), 1);
        write_line(8'h40, mk_line(32'hAA), 1);
        write_line(8'h40, mk_line(32'hBB), 1);
`ifdef WBUF_COALESCE_EN
        check("dup_count", 32'(count), 2);
`else
        check("dup_count", 32'(count), 3);
`endif
        read_hit(8'h40, mk_line(32'hBB));
        drain_one(8'h50, mk_line(32'h50));
`ifndef WBUF_COALESCE_EN
        drain_one(8'h40, mk_line(32'hAA));
`endif
        drain_one(8'h40, mk_line(32'hBB));
        check("dup_drained", 32'(count), 0);

        // Reset in mid-operation
        write_line(8'h61, mk_line(32'h61), 1);
        write_line(8'h62, mk_line(32'h62), 1);
        write_line(8'h63, mk_line(32'h63), 1);
        check("pre_rst_count", 32'(count), 3);
        check("pre_rst_wr", 32'(dn_wr_req), 1);
        rst = 1'b1;
        step();
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_wr", 32'(dn_wr_req), 0);
        check("mid_rst_gnt", 32'(up_gnt), 0);
        check("mid_rst_full", 32'(full), 0);
        rst = 1'b0;
        step();
        check("post_rst_wr", 32'(dn_wr_req), 0);
        check("post_rst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
